// File: rtl/ghost_pkg.sv
// ============================================================================
//  Module   : ghost_pkg
//  Brief    : Shared ghost constants, state encoding and phase-length lookup.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ghost_pkg;

   localparam logic [3:0] c_mode_chase   = 4'b1000;
   localparam logic [3:0] c_mode_scatter = 4'b0100;
   localparam logic [3:0] c_mode_fright  = 4'b0010;
   localparam logic [3:0] c_mode_eaten   = 4'b0001;

   // Direction vectors as packed {dx, dy} signed bytes
   localparam logic [15:0] c_dir_left  = 16'hFF00;
   localparam logic [15:0] c_dir_right = 16'h0100;
   localparam logic [15:0] c_dir_up    = 16'h00FF;
   localparam logic [15:0] c_dir_down  = 16'h0001;

   typedef enum logic [1:0] {
      ST_SCATTER = 2'd0,
      ST_CHASE   = 2'd1,
      ST_FRIGHT  = 2'd2,
      ST_EATEN   = 2'd3
   } ghost_state_t;

   // Odd phases are chase; phases 4 and 6 use the short scatter length
   function automatic logic [15:0] phase_len(input logic [2:0]  p,
                                             input logic [15:0] scatter,
                                             input logic [15:0] scatter_short,
                                             input logic [15:0] chase);
      if (p[0])
         return chase;
      else if (p[2])
         return scatter_short;
      else
         return scatter;
   endfunction

   function automatic logic [3:0] state_mode(input ghost_state_t s);
      case (s)
         ST_CHASE:  return c_mode_chase;
         ST_FRIGHT: return c_mode_fright;
         ST_EATEN:  return c_mode_eaten;
         default:   return c_mode_scatter;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/ghost_tick_gen.sv
// ============================================================================
//  Module   : ghost_tick_gen
//  Brief    : Step-rate divider producing the update square wave and commit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghost_tick_gen #(
   parameter int TICK_DIV = 833333
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic update,
   output logic commit
);

   localparam int            CW     = $clog2(TICK_DIV);
   localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] c_half = CW'(TICK_DIV / 2);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;
   logic          r_update;

   assign w_cnt_next = (r_cnt == c_last) ? '0 : r_cnt + CW'(1);

   // r_update tracks the half of the period r_cnt sits in, from a flop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_update <= 1'b0;
      end else if (enable) begin
         r_cnt    <= w_cnt_next;
         r_update <= (w_cnt_next < c_half);
      end
   end

   assign update = r_update & enable;
   assign commit = enable & (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/ghost_mode_ctrl.sv
// ============================================================================
//  Module   : ghost_mode_ctrl
//  Brief    : Ghost mode scheduler: scatter/chase phases, fright and eaten.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghost_mode_ctrl
   import ghost_pkg::*;
#(
   parameter int TICK_DIV      = 833333,
   parameter int SCATTER_TICKS = 420,
   parameter int SCATTER_SHORT = 300,
   parameter int CHASE_TICKS   = 1200,
   parameter int FRIGHT_TICKS  = 360,
   parameter int FLASH_TICKS   = 120
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       energizer_eaten,
   input  logic       ghost_caught,
   input  logic       ghost_home,
   output logic [3:0] mode,
   output logic       rotate,
   output logic       update,
   output logic [2:0] phase,
   output logic       fright_flash
);

   localparam logic [15:0] c_scatter = 16'(SCATTER_TICKS);
   localparam logic [15:0] c_short   = 16'(SCATTER_SHORT);
   localparam logic [15:0] c_chase   = 16'(CHASE_TICKS);
   localparam logic [15:0] c_fright  = 16'(FRIGHT_TICKS);
   localparam logic [15:0] c_flash   = 16'(FLASH_TICKS);

   logic w_commit;

   ghost_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .update (update),
      .commit (w_commit)
   );

   ghost_state_t r_state;
   logic [2:0]   r_phase;
   logic [15:0]  r_ptimer;
   logic [15:0]  r_ftimer;
   logic         r_energ_pend;
   logic         r_caught_pend;
   logic [3:0]   r_mode;
   logic         r_rotate;
   logic         r_flash;

   ghost_state_t w_state_n;
   ghost_state_t w_sched_state;
   logic [2:0]   w_phase_n;
   logic [15:0]  w_ptimer_n;
   logic [15:0]  w_ftimer_n;
   logic         w_rotate_n;
   logic         w_adv;
   logic         w_energ;
   logic         w_caught;
   logic         w_sched_run;

   // Events arriving in the commit cycle itself are honoured immediately
   assign w_energ     = r_energ_pend | energizer_eaten;
   assign w_caught    = r_caught_pend | ghost_caught;
   assign w_sched_run = (r_state == ST_SCATTER) || (r_state == ST_CHASE);

   always_comb begin
      w_phase_n  = r_phase;
      w_ptimer_n = r_ptimer;
      w_adv      = 1'b0;
      if (w_sched_run && (r_phase != 3'd7)) begin
         if (r_ptimer <= 16'd1) begin
            w_adv      = 1'b1;
            w_phase_n  = r_phase + 3'd1;
            w_ptimer_n = phase_len(w_phase_n, c_scatter, c_short, c_chase);
         end else begin
            w_ptimer_n = r_ptimer - 16'd1;
         end
      end
   end

   assign w_sched_state = w_phase_n[0] ? ST_CHASE : ST_SCATTER;

   always_comb begin
      w_state_n  = r_state;
      w_ftimer_n = r_ftimer;
      w_rotate_n = 1'b0;
      case (r_state)
         ST_SCATTER, ST_CHASE: begin
            if (w_energ) begin
               w_state_n  = ST_FRIGHT;
               w_ftimer_n = c_fright;
               w_rotate_n = 1'b1;
            end else begin
               w_state_n  = w_sched_state;
               w_rotate_n = w_adv;
            end
         end
         ST_FRIGHT: begin
            if (w_caught) begin
               w_state_n  = ST_EATEN;
               w_ftimer_n = 16'd0;
            end else if (w_energ) begin
               w_ftimer_n = c_fright;
            end else if (r_ftimer <= 16'd1) begin
               w_ftimer_n = 16'd0;
               w_state_n  = w_sched_state;
            end else begin
               w_ftimer_n = r_ftimer - 16'd1;
            end
         end
         default: begin
            if (ghost_home)
               w_state_n = w_sched_state;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_SCATTER;
         r_phase       <= 3'd0;
         r_ptimer      <= c_scatter;
         r_ftimer      <= 16'd0;
         r_energ_pend  <= 1'b0;
         r_caught_pend <= 1'b0;
         r_mode        <= c_mode_scatter;
         r_rotate      <= 1'b0;
         r_flash       <= 1'b0;
      end else if (w_commit) begin
         r_state       <= w_state_n;
         r_phase       <= w_phase_n;
         r_ptimer      <= w_ptimer_n;
         r_ftimer      <= w_ftimer_n;
         r_energ_pend  <= 1'b0;
         r_caught_pend <= 1'b0;
         r_mode        <= state_mode(w_state_n);
         r_rotate      <= w_rotate_n;
         r_flash       <= (w_state_n == ST_FRIGHT) && (w_ftimer_n <= c_flash);
      end else begin
         r_energ_pend  <= r_energ_pend | energizer_eaten;
         r_caught_pend <= r_caught_pend | ghost_caught;
      end
   end

   assign mode         = r_mode;
   assign rotate       = r_rotate;
   assign phase        = r_phase;
   assign fright_flash = r_flash;

endmodule

`default_nettype wire

// File: tb/tb_ghost_mode_ctrl.sv
// ============================================================================
//  Module   : tb_ghost_mode_ctrl
//  Brief    : Directed self-checking bench for ghost_mode_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ghost_mode_ctrl;

   localparam int TD = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       energizer_eaten = 1'b0;
   logic       ghost_caught = 1'b0;
   logic       ghost_home = 1'b0;
   logic [3:0] mode;
   logic       rotate;
   logic       update;
   logic [2:0] phase;
   logic       fright_flash;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   ghost_mode_ctrl #(
      .TICK_DIV      (TD),
      .SCATTER_TICKS (3),
      .SCATTER_SHORT (2),
      .CHASE_TICKS   (5),
      .FRIGHT_TICKS  (4),
      .FLASH_TICKS   (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .energizer_eaten (energizer_eaten),
      .ghost_caught    (ghost_caught),
      .ghost_home      (ghost_home),
      .mode            (mode),
      .rotate          (rotate),
      .update          (update),
      .phase           (phase),
      .fright_flash    (fright_flash)
   );

   // Advance n whole update periods; starts and ends on the first cycle after a commit
   task automatic step(input int n);
      repeat (n * TD) @(negedge clock);
   endtask

   task automatic pulse_step(input logic e, input logic c);
      @(negedge clock);
      energizer_eaten = e;
      ghost_caught    = c;
      @(negedge clock);
      energizer_eaten = 1'b0;
      ghost_caught    = 1'b0;
      repeat (TD - 2) @(negedge clock);
   endtask

   // Find the first update rise that follows a fall: that cycle follows a commit
   task automatic sync();
      bit seen1, seen0, found;
      int n;
      seen1 = (update === 1'b1);
      seen0 = 1'b0;
      found = 1'b0;
      n = 0;
      while (!found && n < 40) begin
         @(negedge clock);
         n++;
         if (!seen1) seen1 = (update === 1'b1);
         else if (!seen0) seen0 = (update === 1'b0);
         else if (update === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL sync_timeout got=no_update_edge exp=edge_within_40_clocks");
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      energizer_eaten = 1'b0;
      ghost_caught = 1'b0;
      ghost_home = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      enable = 1'b1;
      sync();
   endtask

   task automatic test_reset();
      logic [4:0] pat;
      int hi;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++; if (mode !== 4'b0100) begin failures++; $display("FAIL rst_mode got=%b exp=0100", mode); end
      checks++; if ({rotate, update, fright_flash} !== 3'b000) begin failures++; $display("FAIL rst_bits got=%b exp=000", {rotate, update, fright_flash}); end
      checks++; if (phase !== 3'd0) begin failures++; $display("FAIL rst_phase got=%0d exp=0", phase); end
      reset = 1'b0;
      enable = 1'b1;
      sync();
      // commit 1 done: scatter, timer 3->2
      pat[4] = update;
      for (int i = 3; i >= 0; i--) begin
         @(negedge clock);
         pat[i] = update;
      end
      checks++; if (pat !== 5'b11001) begin failures++; $display("FAIL update_pattern got=%b exp=11001", pat); end
      // commit 2 done; look at the cycle just before commit 3
      repeat (3) @(negedge clock);
      checks++; if ({mode, rotate} !== 5'b0100_0) begin failures++; $display("FAIL pre_phase1 got=%b exp=01000", {mode, rotate}); end
      @(negedge clock);
      checks++; if (mode !== 4'b1000 || phase !== 3'd1) begin failures++; $display("FAIL phase1_entry got=mode %b phase %0d exp=mode 1000 phase 1", mode, phase); end
      hi = 0;
      for (int i = 0; i < 5; i++) begin
         if (rotate === 1'b1) hi++;
         if (i < 4) @(negedge clock);
      end
      checks++; if (hi != 4) begin failures++; $display("FAIL rotate_width got=%0d exp=4", hi); end
   endtask

   task automatic test_schedule();
      int bnd[7] = '{3, 8, 11, 16, 18, 23, 25};
      int ep;
      logic er;
      logic [3:0] em;
      // continues from commit 4 of test_reset
      for (int c = 5; c <= 34; c++) begin
         step(1);
         ep = 0;
         er = 1'b0;
         for (int k = 0; k < 7; k++) begin
            if (bnd[k] <= c) ep++;
            if (bnd[k] == c) er = 1'b1;
         end
         em = (ep % 2 == 1) ? 4'b1000 : 4'b0100;
         checks++; if (phase !== 3'(ep)) begin failures++; $display("FAIL sched_phase c=%0d got=%0d exp=%0d", c, phase, ep); end
         checks++; if (mode !== em) begin failures++; $display("FAIL sched_mode c=%0d got=%b exp=%b", c, mode, em); end
         checks++; if (rotate !== er) begin failures++; $display("FAIL sched_rotate c=%0d got=%b exp=%b", c, rotate, er); end
      end
   endtask

   task automatic test_fright();
      logic [3:0] em [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
      logic       ef [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       er [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0] ep [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      do_reset();
      @(negedge clock); energizer_eaten = 1'b1;
      @(negedge clock); energizer_eaten = 1'b0;
      @(negedge clock);
      checks++; if (mode !== 4'b0100) begin failures++; $display("FAIL fr_before_commit got=%b exp=0100", mode); end
      @(negedge clock);
      checks++; if ({mode, rotate, fright_flash} !== 6'b0010_1_0) begin failures++; $display("FAIL fr_entry got=%b exp=001010", {mode, rotate, fright_flash}); end
      for (int i = 0; i < 5; i++) begin
         step(1);
         checks++; if ({mode, rotate, fright_flash, phase} !== {em[i], er[i], ef[i], ep[i]}) begin
            failures++;
            $display("FAIL fr_seq c=%0d got=mode %b rot %b flash %b phase %0d exp=mode %b rot %b flash %b phase %0d",
                     i + 3, mode, rotate, fright_flash, phase, em[i], er[i], ef[i], ep[i]);
         end
      end
   endtask

   task automatic test_eaten();
      do_reset();
      pulse_step(1'b1, 1'b0);
      checks++; if (mode !== 4'b0010) begin failures++; $display("FAIL eat_fright got=%b exp=0010", mode); end
      pulse_step(1'b1, 1'b1);
      checks++; if ({mode, rotate} !== 5'b0001_0) begin failures++; $display("FAIL eat_entry got=%b exp=00010", {mode, rotate}); end
      for (int c = 4; c <= 13; c++) begin
         if (c == 5) pulse_step(1'b1, 1'b0);
         else step(1);
         checks++; if ({mode, rotate, phase} !== {4'b0001, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL eat_hold c=%0d got=mode %b rot %b phase %0d exp=mode 0001 rot 0 phase 0", c, mode, rotate, phase);
         end
      end
      ghost_home = 1'b1;
      step(1);
      ghost_home = 1'b0;
      checks++; if ({mode, rotate, phase} !== {4'b0100, 1'b0, 3'd0}) begin failures++; $display("FAIL eat_home got=mode %b rot %b phase %0d exp=mode 0100 rot 0 phase 0", mode, rotate, phase); end
      step(1);
      checks++; if ({mode, rotate, phase} !== {4'b1000, 1'b1, 3'd1}) begin failures++; $display("FAIL eat_resume got=mode %b rot %b phase %0d exp=mode 1000 rot 1 phase 1", mode, rotate, phase); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(1);
      repeat (3) @(negedge clock);
      energizer_eaten = 1'b1;
      @(negedge clock);
      energizer_eaten = 1'b0;
      checks++; if ({mode, rotate, phase} !== {4'b0010, 1'b1, 3'd1}) begin failures++; $display("FAIL b2b_entry got=mode %b rot %b phase %0d exp=mode 0010 rot 1 phase 1", mode, rotate, phase); end
      step(1);
      checks++; if ({mode, rotate} !== 5'b0010_0) begin failures++; $display("FAIL b2b_single_rot got=%b exp=00100", {mode, rotate}); end
      step(3);
      checks++; if ({mode, rotate, phase} !== {4'b1000, 1'b0, 3'd1}) begin failures++; $display("FAIL b2b_exit got=mode %b rot %b phase %0d exp=mode 1000 rot 0 phase 1", mode, rotate, phase); end
   endtask

   task automatic test_async_reset_freeze();
      bit bad;
      do_reset();
      pulse_step(1'b1, 1'b0);
      checks++; if ({mode, update} !== 5'b0010_1) begin failures++; $display("FAIL ar_pre got=%b exp=00101", {mode, update}); end
      reset = 1'b1;
      #1;
      checks++; if ({mode, rotate, update, phase, fright_flash} !== {4'b0100, 1'b0, 1'b0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL ar_immediate got=%b exp=0100000000", {mode, rotate, update, phase, fright_flash});
      end
      @(negedge clock);
      reset = 1'b0;
      sync();
      pulse_step(1'b1, 1'b0);
      enable = 1'b0;
      #1;
      checks++; if (update !== 1'b0) begin failures++; $display("FAIL frz_update got=%b exp=0", update); end
      bad = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if ({update, mode, rotate, phase, fright_flash} !== {1'b0, 4'b0010, 1'b1, 3'd0, 1'b0}) bad = 1'b1;
      end
      checks++; if (bad) begin failures++; $display("FAIL frz_hold got=changed exp=held"); end
      enable = 1'b1;
      #1;
      checks++; if (update !== 1'b1) begin failures++; $display("FAIL frz_resume_update got=%b exp=1", update); end
      step(1);
      checks++; if ({mode, rotate, fright_flash} !== 6'b0010_0_0) begin failures++; $display("FAIL frz_c3 got=%b exp=001000", {mode, rotate, fright_flash}); end
      step(1);
      checks++; if ({mode, rotate, fright_flash} !== 6'b0010_0_1) begin failures++; $display("FAIL frz_c4 got=%b exp=001001", {mode, rotate, fright_flash}); end
   endtask

   initial begin
      test_reset();
      test_schedule();
      test_fright();
      test_eaten();
      test_back_to_back();
      test_async_reset_freeze();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
